// File: rtl/ifr_pkg.sv
// Shared constants for the instruction fetch responder: FSM encodings,
// the ebreak word returned on faulting fetches, and the default base address.
package ifr_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
  localparam logic [31:0] IFR_BASE_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifr_ram.sv
// Word-addressed instruction RAM: one synchronous write port, one synchronous
// read port with a held output register; a same-edge write returns the old word.
module ifr_ram #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [31:0]           rd_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register only moves on a read, so later writes never disturb a held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_fetch_responder.sv
// Memory end of the core fetch interface: accepts one fetch address at a time and
// returns the instruction word (or ebreak plus error) after a fixed latency.
module inst_fetch_responder
  import ifr_pkg::*;
#(
  parameter logic [31:0] BASE       = IFR_BASE_DEFAULT,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_inst,
  output logic                  resp_err,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int unsigned CNT_W = 4;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic                  err_q, err_d;
  logic                  rd_en;
  logic [29:0]           word_off;
  logic [DEPTH_LOG2-1:0] index;
  logic                  fault;
  logic [31:0]           ram_data;

  // Modular subtract: addresses below BASE wrap to a huge offset and fall out of range.
  assign word_off = 30'((addr_q - BASE) >> 2);
  assign index    = word_off[DEPTH_LOG2-1:0];
  assign fault    = (addr_q[1:0] != 2'b00) || (word_off[29:DEPTH_LOG2] != '0);

  assign req_ready  = (state_q == ST_IDLE) && rst;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = err_q;
  assign resp_inst  = err_q ? INST_EBREAK : ram_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end else begin
          err_d   = fault;
          rd_en   = !fault;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ifr_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (load_en),
    .wr_addr(load_addr),
    .wr_data(load_data),
    .rd_en  (rd_en),
    .rd_addr(index),
    .rd_data(ram_data)
  );

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Scoreboard bench for inst_fetch_responder: two instances (LATENCY 1 and 3)
// driven by directed fetches; a monitor checks latency, data and error per response.
module tb_inst_fetch_responder;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_inst  [2];
  logic        resp_err   [2];
  logic        load_en    [2];
  logic [9:0]  load_addr  [2];
  logic [31:0] load_data  [2];

  exp_t q0[$];
  exp_t q1[$];
  bit   seen [2];
  int   lat  [2] = '{1, 3};
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] stream_words [8] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213,
                                    32'h0050_0293, 32'h0060_0313, 32'h0070_0393, 32'h0080_0413};

  inst_fetch_responder #(.BASE(32'h8000_0000), .DEPTH_LOG2(10), .LATENCY(1)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_inst(resp_inst[0]), .resp_err(resp_err[0]),
    .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0])
  );

  inst_fetch_responder #(.BASE(32'h8000_0000), .DEPTH_LOG2(10), .LATENCY(3)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_inst(resp_inst[1]), .resp_err(resp_err[1]),
    .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] inst, input logic err, input int due);
    exp_t e;
    e.inst = inst;
    e.err  = err;
    e.due  = due;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] ei, input logic ee);
    bit ok = 1'b0;
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        push_exp(d, ei, ee, cyc + 1 + lat[d]);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid[d] = 1'b0;
    chk("req_accept", 32'(ok), 32'd1);
  endtask

  task automatic do_load(input int d, input logic [9:0] idx, input logic [31:0] data);
    load_en[d]   = 1'b1;
    load_addr[d] = idx;
    load_data[d] = data;
    @(posedge clk); #1;
    load_en[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d);
    bit ok = 1'b0;
    for (int k = 0; k < 32 && !ok; k++) begin
      @(negedge clk);
      if (resp_valid[d]) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("resp_wait", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: latency on first sight of resp_valid, payload on handshake.
  always @(negedge clk) begin
    exp_t front;
    int   sz;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        seen[d] = 1'b0;
      end else if (resp_valid[d]) begin
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
          chk("unexpected_resp", resp_inst[d], 32'hxxxx_xxxx);
        end else begin
          front = (d == 0) ? q0[0] : q1[0];
          if (!seen[d]) begin
            chk("resp_latency", 32'(cyc), 32'(front.due));
            seen[d] = 1'b1;
          end
          if (resp_ready[d]) begin
            chk("resp_inst", resp_inst[d], front.inst);
            chk("resp_err", 32'(resp_err[d]), 32'(front.err));
            if (d == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
            seen[d] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = '0; resp_ready[d] = 1'b1;
      load_en[d] = 1'b0; load_addr[d] = '0; load_data[d] = '0;
    end
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_resp_inst", resp_inst[d], 32'd0);
      chk("rst_resp_err", 32'(resp_err[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;

    do_load(0, 10'd0, 32'h0000_0413);
    do_load(0, 10'd5, 32'hAAAA_AAAA);
    do_load(0, 10'd1023, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) do_load(0, 10'(8 + i), stream_words[i]);
    do_load(1, 10'd0, 32'h1234_5678);

    // basic fetch, LATENCY 1
    do_req(0, 32'h8000_0000, 32'h0000_0413, 1'b0);
    idle(3);

    // faults and the last in-range word
    do_req(0, 32'h8000_0002, 32'h0010_0073, 1'b1);
    do_req(0, 32'h7FFF_FFFC, 32'h0010_0073, 1'b1);
    do_req(0, 32'h8000_1000, 32'h0010_0073, 1'b1);
    do_req(0, 32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0);
    do_req(0, 32'h8000_0003, 32'h0010_0073, 1'b1);
    idle(4);

    // write to word 5 on the same edge it is read: old data returned
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h8000_0014;
    @(negedge clk);
    chk("t5_ready", 32'(req_ready[0]), 32'd1);
    push_exp(0, 32'hAAAA_AAAA, 1'b0, cyc + 2);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    load_en[0] = 1'b1; load_addr[0] = 10'd5; load_data[0] = 32'h5555_5555;
    @(posedge clk); #1;
    load_en[0] = 1'b0;
    do_req(0, 32'h8000_0014, 32'h5555_5555, 1'b0);
    idle(4);

    // streaming sequential PCs
    for (int i = 0; i < 8; i++) do_req(0, 32'h8000_0020 + 32'(4 * i), stream_words[i], 1'b0);
    idle(6);

    // LATENCY 3 with a stalled consumer; a write after the read edge must not show
    resp_ready[1] = 1'b0;
    do_req(1, 32'h8000_0000, 32'h1234_5678, 1'b0);
    wait_valid(1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        load_en[1] = 1'b1; load_addr[1] = 10'd0; load_data[1] = 32'hFFFF_FFFF;
      end else begin
        load_en[1] = 1'b0;
      end
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid[1]), 32'd1);
      chk("hold_inst", resp_inst[1], 32'h1234_5678);
      chk("hold_err", 32'(resp_err[1]), 32'd0);
      chk("hold_req_ready", 32'(req_ready[1]), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready[1] = 1'b1;
    idle(3);

    // reset while a response is held: it must vanish for good
    resp_ready[1] = 1'b0;
    do_req(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_valid(1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid[1]), 32'd0);
    chk("midrst_req_ready", 32'(req_ready[1]), 32'd0);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    resp_ready[1] = 1'b1;
    @(negedge clk);
    chk("after_rst_ready", 32'(req_ready[1]), 32'd1);
    chk("after_rst_valid", 32'(resp_valid[1]), 32'd0);
    @(posedge clk); #1;
    idle(8);
    do_req(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(8);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
